// File: rtl/axis_distrib_buf_pkg.sv
// Shared helpers for the AXI-stream buffered distributor: log2 and FIFO level width.
package axis_distrib_buf_pkg;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

  // Level counter must hold 0..depth inclusive.
  function automatic int unsigned level_width(input int unsigned depth);
    return log2(depth) + 1;
  endfunction

endpackage

// File: rtl/axis_distrib_buf_fifo.sv
// Per-channel FIFO: power-of-two depth, level-based full/empty, head entry gated to zero when empty.
module axis_distrib_buf_fifo
  import axis_distrib_buf_pkg::*;
#(
  parameter int unsigned WIDTH = 257,
  parameter int unsigned DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [WIDTH-1:0]              wr_data,
  output logic                          full,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [WIDTH-1:0]              rd_data,
  output logic [level_width(DEPTH)-1:0] level
);

  localparam int unsigned PTR_W = log2(DEPTH);
  localparam int unsigned LVL_W = level_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [LVL_W-1:0] level_q;
  logic             wr_fire;
  logic             rd_fire;

  // Full uses the registered level, so a same-cycle read never frees space for a write.
  assign full     = (level_q == LVL_W'(DEPTH));
  assign rd_valid = (level_q != '0);
  assign wr_fire  = wr_en & ~full;
  assign rd_fire  = rd_valid & rd_ready;
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign level    = level_q;

  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (rd_fire) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({wr_fire, rd_fire})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/axis_distrib_buf.sv
// AXI-stream broadcaster: each accepted beat is copied into a FIFO per enabled channel;
// the channel mask is latched at packet start and held until tlast.
module axis_distrib_buf
  import axis_distrib_buf_pkg::*;
#(
  parameter int unsigned NUM_DISTRIB = 6,
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_DISTRIB-1:0]            en_mask,
  input  logic                              s_axis_tvalid,
  output logic                              s_axis_tready,
  input  logic [DATA_WIDTH-1:0]             s_axis_tdata,
  input  logic                              s_axis_tlast,
  output logic [NUM_DISTRIB-1:0]            m_axis_tvalid,
  input  logic [NUM_DISTRIB-1:0]            m_axis_tready,
  output logic [NUM_DISTRIB*DATA_WIDTH-1:0] m_axis_tdata,
  output logic [NUM_DISTRIB-1:0]            m_axis_tlast,
  output logic                              pkt_active,
  output logic [NUM_DISTRIB-1:0]            act_mask
);

  localparam int unsigned LEVEL_WIDTH = level_width(FIFO_DEPTH);
  localparam int unsigned ENTRY_W     = DATA_WIDTH + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_e;

  state_e                 state_q;
  logic [NUM_DISTRIB-1:0] act_mask_q;
  logic [NUM_DISTRIB-1:0] mask_cur;
  logic [NUM_DISTRIB-1:0] fifo_full;
  logic [NUM_DISTRIB-1:0] wr_en;
  logic                   accept;
  logic [LEVEL_WIDTH-1:0] level_unused [NUM_DISTRIB];

  // Outside a packet the live request applies; inside, the latched mask is frozen.
  assign mask_cur      = (state_q == ST_PKT) ? act_mask_q : en_mask;
  assign s_axis_tready = rst_n & (&(~mask_cur | ~fifo_full));
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign wr_en         = {NUM_DISTRIB{accept}} & mask_cur;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      act_mask_q <= '0;
    end else if (accept) begin
      if (state_q == ST_IDLE) act_mask_q <= en_mask;
      state_q <= s_axis_tlast ? ST_IDLE : ST_PKT;
    end
  end

  assign pkt_active = (state_q == ST_PKT);
  assign act_mask   = act_mask_q;

  for (genvar n = 0; n < NUM_DISTRIB; n++) begin : g_ch
    logic [ENTRY_W-1:0] rd_entry;

    axis_distrib_buf_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (wr_en[n]),
      .wr_data  ({s_axis_tlast, s_axis_tdata}),
      .full     (fifo_full[n]),
      .rd_valid (m_axis_tvalid[n]),
      .rd_ready (m_axis_tready[n]),
      .rd_data  (rd_entry),
      .level    (level_unused[n])
    );

    assign m_axis_tdata[n*DATA_WIDTH +: DATA_WIDTH] = rd_entry[DATA_WIDTH-1:0];
    assign m_axis_tlast[n]                          = rd_entry[DATA_WIDTH];
  end

endmodule

// File: tb/tb_axis_distrib_buf.sv
// Bench for axis_distrib_buf: per-channel queue model, stimulus tables, stall/reset sequences, random traffic.
module tb_axis_distrib_buf;

  localparam int unsigned N  = 6;
  localparam int unsigned DW = 256;
  localparam int unsigned D  = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    en_mask;
  logic            s_axis_tvalid;
  logic            s_axis_tready;
  logic [DW-1:0]   s_axis_tdata;
  logic            s_axis_tlast;
  logic [N-1:0]    m_axis_tvalid;
  logic [N-1:0]    m_axis_tready;
  logic [N*DW-1:0] m_axis_tdata;
  logic [N-1:0]    m_axis_tlast;
  logic            pkt_active;
  logic [N-1:0]    act_mask;

  axis_distrib_buf #(
    .NUM_DISTRIB (N),
    .DATA_WIDTH  (DW),
    .FIFO_DEPTH  (D)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .en_mask       (en_mask),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .pkt_active    (pkt_active),
    .act_mask      (act_mask)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: one queue of {tlast,tdata} per channel plus packet state.
  logic [DW:0]  mq [N][$];
  bit           m_inpkt;
  logic [N-1:0] m_act;

  typedef struct {
    logic [N-1:0] en;
    logic [7:0]   data;
    logic         last;
    logic         exp_rdy;
    logic         exp_pkt;
    logic [N-1:0] exp_act;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < N; n++) mq[n].delete();
    m_inpkt = 0;
    m_act   = '0;
  endtask

  function automatic bit pending();
    bit p;
    p = 0;
    for (int n = 0; n < N; n++) if (mq[n].size() != 0) p = 1;
    return p;
  endfunction

  // One clock: check DUT against model at negedge, then advance model past the posedge.
  task automatic cycle(output bit acc, output logic rdy_seen);
    logic [N-1:0] mc;
    logic [N-1:0] expv;
    logic [N-1:0] pop;
    logic         rdy;
    logic [DW:0]  ent;
    logic [DW:0]  in_ent;
    @(negedge clk);
    mc  = m_inpkt ? m_act : en_mask;
    rdy = 1'b1;
    for (int n = 0; n < N; n++) begin
      if (mc[n] && mq[n].size() >= D) rdy = 1'b0;
      expv[n] = (mq[n].size() != 0);
    end
    rdy_seen = s_axis_tready;
    chk("s_tready", DW'(s_axis_tready), DW'(rdy));
    chk("m_tvalid", DW'(m_axis_tvalid), DW'(expv));
    chk("pkt_active", DW'(pkt_active), DW'(m_inpkt));
    chk("act_mask", DW'(act_mask), DW'(m_act));
    for (int n = 0; n < N; n++) begin
      if (expv[n]) begin
        ent = mq[n][0];
        chk($sformatf("ch%0d_tdata", n), m_axis_tdata[n*DW +: DW], ent[DW-1:0]);
        chk($sformatf("ch%0d_tlast", n), DW'(m_axis_tlast[n]), DW'(ent[DW]));
      end
    end
    acc    = s_axis_tvalid & rdy;
    pop    = expv & m_axis_tready;
    in_ent = {s_axis_tlast, s_axis_tdata};
    @(posedge clk);
    #1;
    for (int n = 0; n < N; n++) if (pop[n]) void'(mq[n].pop_front());
    if (acc) begin
      for (int n = 0; n < N; n++) if (mc[n]) mq[n].push_back(in_ent);
      m_act   = mc;
      m_inpkt = !in_ent[DW];
    end
  endtask

  task automatic drain();
    bit   a;
    logic r;
    s_axis_tvalid = 1'b0;
    m_axis_tready = '1;
    for (int c = 0; c < 20 && pending(); c++) cycle(a, r);
    chk("drain_empty", DW'(pending()), DW'(0));
  endtask

  task automatic run_table(input string tag);
    bit   a;
    logic r;
    foreach (tbl[i]) begin
      en_mask       = tbl[i].en;
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = DW'(tbl[i].data);
      s_axis_tlast  = tbl[i].last;
      cycle(a, r);
      chk($sformatf("%s[%0d]_tready", tag, i), DW'(r), DW'(tbl[i].exp_rdy));
      chk($sformatf("%s[%0d]_pkt", tag, i), DW'(pkt_active), DW'(tbl[i].exp_pkt));
      chk($sformatf("%s[%0d]_act", tag, i), DW'(act_mask), DW'(tbl[i].exp_act));
    end
    s_axis_tvalid = 1'b0;
    tbl.delete();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    bit           a;
    logic         r;
    int           i;
    logic [DW-1:0] d;

    // Reset with valid asserted
    model_reset();
    rst_n         = 1'b0;
    en_mask       = 6'h3F;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = DW'(8'hA5);
    s_axis_tlast  = 1'b1;
    m_axis_tready = '1;
    #12;
    chk("rst_tready", DW'(s_axis_tready), DW'(0));
    chk("rst_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("rst_act", DW'(act_mask), DW'(0));
    chk("rst_pkt", DW'(pkt_active), DW'(0));
    chk("rst_tdata", m_axis_tdata[DW-1:0], DW'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(a, r);
    chk("first_beat_rdy", DW'(r), DW'(1));
    chk("first_beat_out", DW'(m_axis_tvalid), DW'(6'h3F));
    chk("first_beat_act", DW'(act_mask), DW'(6'h3F));
    chk("first_beat_pkt", DW'(pkt_active), DW'(0));
    drain();

    // Broadcast 0..7, tlast on 7
    for (int k = 0; k < 8; k++)
      tbl.push_back('{6'h3F, 8'(k), k == 7, 1'b1, k != 7, 6'h3F});
    run_table("bcast");
    drain();

    // Mask change mid-packet takes effect only at the next packet
    for (int k = 0; k < 5; k++)
      tbl.push_back('{(k < 3) ? 6'h3F : 6'h01, 8'(8'h20 + k), k == 4, 1'b1, k != 4, 6'h3F});
    tbl.push_back('{6'h01, 8'h30, 1'b0, 1'b1, 1'b1, 6'h01});
    tbl.push_back('{6'h01, 8'h31, 1'b1, 1'b1, 1'b0, 6'h01});
    run_table("mask");
    drain();

    // Empty mask: beats discarded, FSM still tracks tlast
    for (int k = 0; k < 3; k++)
      tbl.push_back('{6'h00, 8'(8'h40 + k), k == 2, 1'b1, k != 2, 6'h00});
    run_table("empty");
    for (int k = 0; k < 2; k++) cycle(a, r);
    chk("empty_no_valid", DW'(m_axis_tvalid), DW'(0));

    // Stalled channel 2 with a 10-beat packet
    en_mask       = 6'h3F;
    m_axis_tready = 6'b111011;
    s_axis_tvalid = 1'b1;
    i = 0;
    for (int c = 0; c < 8; c++) begin
      s_axis_tdata = DW'(100 + i);
      s_axis_tlast = (i == 9);
      cycle(a, r);
      if (a) i++;
    end
    chk("stall_accepts", DW'(i), DW'(4));
    chk("stall_tvalid", DW'(m_axis_tvalid), DW'(6'b000100));
    chk("stall_tready_low", DW'(s_axis_tready), DW'(0));
    m_axis_tready = '1;
    for (int c = 0; c < 40 && i < 10; c++) begin
      s_axis_tdata = DW'(100 + i);
      s_axis_tlast = (i == 9);
      cycle(a, r);
      if (a) i++;
    end
    chk("stall_resume_all", DW'(i), DW'(10));
    drain();

    // Async reset mid-packet with two entries buffered
    en_mask       = 6'h3F;
    m_axis_tready = '0;
    s_axis_tvalid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      s_axis_tdata = DW'(8'h50 + k);
      s_axis_tlast = 1'b0;
      cycle(a, r);
    end
    chk("pre_rst_pkt", DW'(pkt_active), DW'(1));
    s_axis_tvalid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tvalid", DW'(m_axis_tvalid), DW'(0));
    chk("arst_tlast", DW'(m_axis_tlast), DW'(0));
    chk("arst_tdata", m_axis_tdata[DW-1:0], DW'(0));
    chk("arst_pkt", DW'(pkt_active), DW'(0));
    chk("arst_act", DW'(act_mask), DW'(0));
    chk("arst_tready", DW'(s_axis_tready), DW'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n         = 1'b1;
    m_axis_tready = '1;
    for (int k = 0; k < 3; k++)
      tbl.push_back('{6'h3F, 8'(8'h60 + k), k == 2, 1'b1, k != 2, 6'h3F});
    run_table("post_rst");
    drain();

    // Random traffic against the model
    for (int c = 0; c < 400; c++) begin
      en_mask       = N'($urandom);
      s_axis_tvalid = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = $urandom;
      s_axis_tdata  = d;
      s_axis_tlast  = ($urandom_range(0, 3) == 0);
      for (int n = 0; n < N; n++) m_axis_tready[n] = ($urandom_range(0, 3) != 0);
      cycle(a, r);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
